// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between two valid/ready producers.
// Latency 1 from accept to registered write; readies drop combinationally on full, or on almost_full while a write is in flight.
module fifo_wr_arbiter #(
    parameter int WL    = 8,
    parameter int BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [WL-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [WL-1:0] req1_data,
    output logic          req1_ready,
    input  logic          fifo_full,
    input  logic          fifo_almost_full,
    output logic          fifo_write_rq,
    output logic [WL-1:0] fifo_data_in,
    output logic [1:0]    grant
);
    localparam int CW = $clog2(BURST + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, G0 = 2'd1, G1 = 2'd2} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] beat_q, beat_d;
    logic          last_q, last_d;
    logic          wr_q;
    logic [WL-1:0] data_q;
    logic          stall, acc0, acc1, acc, burst_end;

    // A write already in flight will fill the last slot, so almost_full must stall too.
    assign stall      = fifo_full | (fifo_almost_full & wr_q);
    assign req0_ready = (state_q == G0) & ~stall & ~rst;
    assign req1_ready = (state_q == G1) & ~stall & ~rst;
    assign acc0       = req0_valid & req0_ready;
    assign acc1       = req1_valid & req1_ready;
    assign acc        = acc0 | acc1;
    assign burst_end  = acc & (beat_q == CW'(BURST - 1));

    assign grant         = {state_q == G1, state_q == G0};
    assign fifo_write_rq = wr_q;
    assign fifo_data_in  = data_q;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if ((req0_valid && req1_valid && last_q) || (req0_valid && !req1_valid)) begin
                    state_d = G0;
                    beat_d  = '0;
                    last_d  = 1'b0;
                end else if (req1_valid) begin
                    state_d = G1;
                    beat_d  = '0;
                    last_d  = 1'b1;
                end
            end
            G0: begin
                if (burst_end || !req0_valid) begin
                    if (req1_valid) begin
                        state_d = G1;
                        beat_d  = '0;
                        last_d  = 1'b1;
                    end else if (burst_end) begin
                        beat_d  = '0;
                        last_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (acc0) begin
                    beat_d = beat_q + CW'(1);
                end
            end
            G1: begin
                if (burst_end || !req1_valid) begin
                    if (req0_valid) begin
                        state_d = G0;
                        beat_d  = '0;
                        last_d  = 1'b0;
                    end else if (burst_end) begin
                        beat_d  = '0;
                        last_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (acc1) begin
                    beat_d = beat_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            last_q  <= 1'b1;
            wr_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            last_q  <= last_d;
            wr_q    <= acc;
            if (acc)
                data_q <= acc1 ? req1_data : req0_data;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter against a rule-level arbiter model and an 8-deep FIFO model.
module tb_fifo_wr_arbiter;
    localparam int WL    = 8;
    localparam int BURST = 4;
    localparam int DEPTH = 8;
    localparam int PHASE = 600;
    localparam int NCYC  = 5 * PHASE;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [WL-1:0] req0_data, req1_data;
    logic          fifo_full, fifo_almost_full, fifo_write_rq;
    logic [WL-1:0] fifo_data_in;
    logic [1:0]    grant;

    fifo_wr_arbiter #(.WL(WL), .BURST(BURST)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .fifo_full(fifo_full), .fifo_almost_full(fifo_almost_full),
        .fifo_write_rq(fifo_write_rq), .fifo_data_in(fifo_data_in), .grant(grant)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: owner -1 = nobody, beats = words taken in this grant, last = most recent winner.
    int            owner, beats, last, taken, phase;
    bit            m_wr, e_rdy0, e_rdy1, e_acc0, e_acc1, stall, done, own_v, oth_v;
    logic [WL-1:0] m_dat;
    bit            dut_wr, rd;
    logic [WL-1:0] dut_dat, popped;
    logic [WL-1:0] fq[$];
    logic [6:0]    seq0, seq1, exp0, exp1;

    task grant_to(input int n);
        owner = n;
        beats = 0;
        last  = n;
    endtask

    function automatic bit want(input int ph, input int prod);
        case (ph)
            0: return prod == 0 && $urandom_range(0, 9) != 0;
            1: return 1'b1;
            2: return $urandom_range(0, 2) != 0;
            3: return prod == 1;
            default: return $urandom_range(0, 1) == 1;
        endcase
    endfunction

    initial begin
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        seq0 = '0; seq1 = '0; exp0 = '0; exp1 = '0;
        req0_data = {1'b0, seq0}; req1_data = {1'b1, seq1};
        fifo_full = 1'b0; fifo_almost_full = 1'b0; rd = 1'b0;
        owner = -1; beats = 0; last = 1; m_wr = 1'b0; m_dat = '0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            phase            = cyc / PHASE;
            rst              = (cyc < 2) || ($urandom_range(0, 299) == 0);
            fifo_full        = (fq.size() == DEPTH);
            fifo_almost_full = (fq.size() >= DEPTH - 1);
            case (phase)
                1:       rd = 1'b1;
                2:       rd = ($urandom_range(0, 3) == 0);
                default: rd = ($urandom_range(0, 1) == 1);
            endcase

            @(negedge clk);
            stall  = fifo_full || (fifo_almost_full && m_wr);
            e_rdy0 = !rst && owner == 0 && !stall;
            e_rdy1 = !rst && owner == 1 && !stall;
            e_acc0 = e_rdy0 && req0_valid;
            e_acc1 = e_rdy1 && req1_valid;
            dut_wr  = fifo_write_rq;
            dut_dat = fifo_data_in;
            if (cyc >= 1) begin
                check("grant", 32'(grant), 32'(owner == 1 ? 2 : (owner == 0 ? 1 : 0)));
                check("req0_ready", 32'(req0_ready), 32'(e_rdy0));
                check("req1_ready", 32'(req1_ready), 32'(e_rdy1));
                check("write_rq", 32'(fifo_write_rq), 32'(m_wr));
                check("data_in", 32'(fifo_data_in), 32'(m_dat));
                check("write_while_full", 32'(fifo_write_rq & fifo_full), 32'd0);
            end

            @(posedge clk);
            if (rst) begin
                owner = -1; beats = 0; last = 1; m_wr = 1'b0; m_dat = '0;
            end else begin
                m_wr = e_acc0 || e_acc1;
                if (e_acc0) m_dat = req0_data;
                else if (e_acc1) m_dat = req1_data;
                if (owner < 0) begin
                    if (req0_valid && req1_valid) grant_to(1 - last);
                    else if (req0_valid) grant_to(0);
                    else if (req1_valid) grant_to(1);
                end else begin
                    taken = beats + ((e_acc0 || e_acc1) ? 1 : 0);
                    done  = (e_acc0 || e_acc1) && taken == BURST;
                    own_v = (owner == 0) ? req0_valid : req1_valid;
                    oth_v = (owner == 0) ? req1_valid : req0_valid;
                    if (done || !own_v) begin
                        if (oth_v) grant_to(1 - owner);
                        else if (done) grant_to(owner);
                        else owner = -1;
                    end else begin
                        beats = taken;
                    end
                end
            end

            // FIFO environment: pop first, then land the DUT's write; drained words must keep per-producer order.
            if (rd && fq.size() > 0) begin
                popped = fq.pop_front();
                if (popped[WL-1]) begin
                    check("p1_order", 32'(popped[6:0]), 32'(exp1));
                    exp1++;
                end else begin
                    check("p0_order", 32'(popped[6:0]), 32'(exp0));
                    exp0++;
                end
            end
            if (dut_wr && fq.size() < DEPTH) fq.push_back(dut_dat);

            #1;
            if (e_acc0) begin
                seq0++;
                req0_data  = {1'b0, seq0};
                req0_valid = want(phase, 0);
            end else if (req0_valid && phase >= 4 && $urandom_range(0, 19) == 0) begin
                req0_valid = 1'b0;
            end else if (!req0_valid || phase == 3) begin
                req0_valid = want(phase, 0);
            end
            if (e_acc1) begin
                seq1++;
                req1_data  = {1'b1, seq1};
                req1_valid = want(phase, 1);
            end else if (req1_valid && phase >= 4 && $urandom_range(0, 19) == 0) begin
                req1_valid = 1'b0;
            end else if (!req1_valid || phase == 0) begin
                req1_valid = want(phase, 1);
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
